dma_write_burst_scheduler: RTL
==============================

Name: dma_write_burst_scheduler

Overview:
Sequences the DMA write master by deciding when a full burst may be launched. It watches the clock-crossing FIFO read-side fill level and issues one burst command (start pulse plus destination address) per available burst of data. It advances and wraps the destination address across the PS ring buffer, and counts completed bursts to raise the periodic interrupt trigger. It sits in the m00_axi_aclk domain, between the FIFO and the AXI4 burst engine, and is configured by the AXI-Lite status block.

Parameters:
C_BASE_ADDR, 32'h10000000, ring buffer base byte address
C_BURST_LEN, 256, beats per burst (1..256)
C_DATA_WIDTH, 32, AXI data width in bits; bytes per burst B = C_BURST_LEN*C_DATA_WIDTH/8
C_BUF_SIZE, 8192000, ring size in bytes; must be a multiple of B
C_IRQ_THRESHOLD, 100, completed bursts per interrupt trigger (>=1)
C_COUNT_WIDTH, 15, width of the FIFO read count
C_TIMEOUT_CYCLES, 65535, burst completion watchdog limit (optional feature only)

Ports:
m00_axi_aclk  in  1  sole clock
m00_axi_areset  in  1  synchronous, active-high reset
enable  in  1  level; 0 = stop issuing new bursts after the current one finishes
clear  in  1  1-cycle pulse; zero the address offset and counters (accepted only in IDLE)
fifo_rd_count  in  C_COUNT_WIDTH  words available in the FIFO
burst_start  out  1  1-cycle pulse to the burst engine
burst_addr  out  32  destination address; valid and stable from burst_start until burst_done
burst_done  in  1  1-cycle pulse; B response received
burst_err  in  1  qualified by burst_done; BRESP != OKAY
trigger_interrupt  out  1  1-cycle pulse every C_IRQ_THRESHOLD completed bursts
busy  out  1  high in ISSUE or WAIT_DONE
error  out  1  sticky; cleared only by reset
burst_count  out  32  total completed bursts (wraps modulo 2^32)
wrap_count  out  16  number of ring wraps (wraps modulo 2^16)

Behaviour:
- Reset values:
  - all outputs 0; burst_addr = C_BASE_ADDR
  - offset = 0, irq counter = 0; state IDLE
- Reset mid-burst: state returns to IDLE immediately; any late burst_done is ignored.
- IDLE:
  - clear pulse zeroes offset, burst_count, wrap_count and the irq counter.
  - enable=1 -> WAIT_DATA next cycle.
- WAIT_DATA:
  - enable=0 -> IDLE.
  - Else if fifo_rd_count >= C_BURST_LEN -> ISSUE.
  - Count exactly equal to C_BURST_LEN qualifies.
- ISSUE (one cycle):
  - burst_start=1; burst_addr = C_BASE_ADDR + offset; -> WAIT_DONE.
  - Latency from a qualifying count sample to burst_start: 1 cycle.
- WAIT_DONE:
  - burst_addr held stable; waits for burst_done.
  - A burst_done arriving in any other state is ignored.
  - On burst_done with burst_err=1: error <= 1; offset not advanced; -> ERROR.
  - On burst_done with burst_err=0:
    - burst_count += 1.
    - Offset update: if offset+B == C_BUF_SIZE, then offset <= 0 and wrap_count += 1; else offset += B.
    - irq counter += 1; when it reaches C_IRQ_THRESHOLD, trigger_interrupt pulses 1 cycle later and the counter resets to 0.
    - Next state: WAIT_DATA if enable=1, else IDLE.
- Bursts never overlap: at most one outstanding burst.
- ERROR: terminal. No further burst_start; enable and clear are ignored until reset.
- enable falling during WAIT_DONE does not abort the burst; the block completes it, then goes to IDLE.
- Address arithmetic: offset is 32 bits. burst_addr is a 32-bit sum; overflow is a configuration error and is not checked.

Optional Feature:
- Macro: DMA_WRITE_BURST_SCHEDULER_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counts cycles spent in WAIT_DONE.
  - Reaching C_TIMEOUT_CYCLES sets error and enters ERROR.
  - A burst_done arriving in the same cycle takes priority; the watchdog does not fire.
- When undefined: no watchdog; WAIT_DONE waits indefinitely, and C_TIMEOUT_CYCLES is unused.

Decomposition:
- Package dma_write_pkg:
  - state enum (IDLE, WAIT_DATA, ISSUE, WAIT_DONE, ERROR)
  - bytes-per-burst constant function
  - default base address and ring size constants
- One sub-module, dma_ring_addr_gen:
  - offset register and wrap logic
  - inputs: advance, clear
  - outputs: offset, wrapped pulse
  - reused by any future read-side scheduler.

Test Plan:
- Basic issue: reset, enable=1, fifo_rd_count=255 -> no burst_start. Then count=256 -> burst_start 1 cycle later with burst_addr=0x10000000. After burst_done -> next burst_addr=0x10000400.
- Wrap: C_BUF_SIZE=4096, run 4 bursts -> addresses 0x000, 0x400, 0x800, 0xC00; 5th burst at 0x10000000; wrap_count=1.
- Interrupt: C_IRQ_THRESHOLD=3, complete 7 bursts -> trigger_interrupt pulses after bursts 3 and 6 only; burst_count=7.
- Error: burst_done with burst_err=1 on burst 2 -> error=1, no further burst_start despite count=1000. Reset -> error=0, burst_addr=base.
- Stop mid-burst: enable dropped in WAIT_DONE -> burst completes, state IDLE, no new start. clear then sets offset=0 and burst_count=0.
- Timeout (macro defined, C_TIMEOUT_CYCLES=10): no burst_done -> error after 10 cycles in WAIT_DONE. burst_done on cycle 10 -> no error.

Source files
------------

// File: rtl/dma_write_burst_scheduler_pkg.sv
// Shared types and constants for the DMA write-side burst scheduler and its ring address generator.
package dma_write_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        ERROR     = 3'd4
    } sched_state_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
    localparam int unsigned DEF_BUF_SIZE  = 32'd8192000;

    function automatic int unsigned bytes_per_burst(input int unsigned burst_len,
                                                    input int unsigned data_width);
        return (burst_len * data_width) / 32'd8;
    endfunction

endpackage

// File: rtl/dma_write_burst_scheduler_if.sv
// Burst command handshake between the scheduler (master) and the AXI4 burst engine (slave).
interface dma_write_burst_scheduler_if;
    logic        burst_start;
    logic [31:0] burst_addr;
    logic        burst_done;
    logic        burst_err;

    modport master (
        output burst_start,
        output burst_addr,
        input  burst_done,
        input  burst_err
    );

    modport slave (
        input  burst_start,
        input  burst_addr,
        output burst_done,
        output burst_err
    );
endinterface

// File: rtl/dma_write_burst_scheduler_ring_addr_gen.sv
// Ring-buffer offset generator: advances by one burst per request and wraps to zero at the ring end.
module dma_ring_addr_gen
    import dma_write_pkg::*;
#(
    parameter int unsigned C_BYTES_PER_BURST = 32'd1024,
    parameter int unsigned C_BUF_SIZE        = DEF_BUF_SIZE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        advance,
    output logic [31:0] offset,
    output logic        wrapped
);

    localparam logic [31:0] BPB      = 32'(C_BYTES_PER_BURST);
    localparam logic [31:0] RING_END = 32'(C_BUF_SIZE);

    logic [31:0] offset_r;
    logic [31:0] next_offset_s;
    logic        at_end_s;

    // Candidate next offset and ring-end detection.
    always_comb begin
        next_offset_s = offset_r + BPB;
        at_end_s      = (next_offset_s == RING_END);
        if (advance && at_end_s) begin
            wrapped = 1'b1;
        end else begin
            wrapped = 1'b0;
        end
    end

    // Offset register; wrapped is combinational so the caller can count it on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            offset_r <= 32'd0;
        end else if (clear) begin
            offset_r <= 32'd0;
        end else if (advance) begin
            offset_r <= at_end_s ? 32'd0 : next_offset_s;
        end else begin
            offset_r <= offset_r;
        end
    end

    assign offset = offset_r;

endmodule

// File: rtl/dma_write_burst_scheduler.sv
// Launches one DMA write burst per burst-worth of FIFO data, walks the ring buffer and raises periodic IRQs.
// Optional burst-completion watchdog: define DMA_WRITE_BURST_SCHEDULER_TIMEOUT_EN.
module dma_write_burst_scheduler
    import dma_write_pkg::*;
#(
    parameter logic [31:0] C_BASE_ADDR      = DEF_BASE_ADDR,
    parameter int unsigned C_BURST_LEN      = 32'd256,
    parameter int unsigned C_DATA_WIDTH     = 32'd32,
    parameter int unsigned C_BUF_SIZE       = DEF_BUF_SIZE,
    parameter int unsigned C_IRQ_THRESHOLD  = 32'd100,
    parameter int unsigned C_COUNT_WIDTH    = 32'd15,
    parameter int unsigned C_TIMEOUT_CYCLES = 32'd65535
) (
    input  logic                      m00_axi_aclk,
    input  logic                      m00_axi_areset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [C_COUNT_WIDTH-1:0]  fifo_rd_count,
    dma_write_burst_scheduler_if.master bus,
    output logic                      trigger_interrupt,
    output logic                      busy,
    output logic                      error,
    output logic [31:0]               burst_count,
    output logic [15:0]               wrap_count
);

    localparam int unsigned            BPB           = bytes_per_burst(C_BURST_LEN, C_DATA_WIDTH);
    localparam logic [C_COUNT_WIDTH-1:0] BURST_LEN_CNT = C_COUNT_WIDTH'(C_BURST_LEN);
    localparam logic [31:0]            IRQ_LIM       = 32'(C_IRQ_THRESHOLD);

    // Reject configurations the ring and IRQ logic cannot honour.
    if ((C_BURST_LEN < 32'd1) || (C_BURST_LEN > 32'd256) || (C_IRQ_THRESHOLD < 32'd1) ||
        (BPB == 32'd0) || ((C_BUF_SIZE % BPB) != 32'd0) ||
        (C_TIMEOUT_CYCLES < 32'd1) || (C_TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_cfg
        $error("dma_write_burst_scheduler: invalid parameter combination");
    end

    sched_state_e state_r;
    logic         burst_start_r;
    logic [31:0]  burst_addr_r;
    logic         trigger_r;
    logic         busy_r;
    logic         error_r;
    logic [31:0]  burst_count_r;
    logic [15:0]  wrap_count_r;
    logic [31:0]  irq_cnt_r;
`ifdef DMA_WRITE_BURST_SCHEDULER_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(C_TIMEOUT_CYCLES - 32'd1);
    logic [15:0]  wd_cnt_r;
`endif

    logic [31:0]  offset_s;
    logic         wrapped_s;
    logic         advance_s;
    logic         clear_s;

    // Only a clean completion moves the ring pointer; clear is honoured only while idle.
    always_comb begin
        advance_s = (state_r == WAIT_DONE) && bus.burst_done && !bus.burst_err;
        clear_s   = (state_r == IDLE) && clear;
    end

    dma_ring_addr_gen #(
        .C_BYTES_PER_BURST (BPB),
        .C_BUF_SIZE        (C_BUF_SIZE)
    ) u_ring_addr_gen (
        .clk     (m00_axi_aclk),
        .rst     (m00_axi_areset),
        .clear   (clear_s),
        .advance (advance_s),
        .offset  (offset_s),
        .wrapped (wrapped_s)
    );

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_r       <= IDLE;
            burst_start_r <= 1'b0;
            burst_addr_r  <= C_BASE_ADDR;
            trigger_r     <= 1'b0;
            busy_r        <= 1'b0;
            error_r       <= 1'b0;
            burst_count_r <= 32'd0;
            wrap_count_r  <= 16'd0;
            irq_cnt_r     <= 32'd0;
`ifdef DMA_WRITE_BURST_SCHEDULER_TIMEOUT_EN
            wd_cnt_r      <= 16'd0;
`endif
        end else begin
            burst_start_r <= 1'b0;
            trigger_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (clear) begin
                        burst_count_r <= 32'd0;
                        wrap_count_r  <= 16'd0;
                        irq_cnt_r     <= 32'd0;
                    end
                    if (enable) begin
                        state_r <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (!enable) begin
                        state_r <= IDLE;
                    end else if (fifo_rd_count >= BURST_LEN_CNT) begin
                        state_r       <= ISSUE;
                        burst_start_r <= 1'b1;
                        burst_addr_r  <= C_BASE_ADDR + offset_s;
                        busy_r        <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_r <= WAIT_DONE;
`ifdef DMA_WRITE_BURST_SCHEDULER_TIMEOUT_EN
                    wd_cnt_r <= 16'd0;
`endif
                end
                WAIT_DONE: begin
                    if (bus.burst_done) begin
                        busy_r <= 1'b0;
                        if (bus.burst_err) begin
                            error_r <= 1'b1;
                            state_r <= ERROR;
                        end else begin
                            burst_count_r <= burst_count_r + 32'd1;
                            if (wrapped_s) begin
                                wrap_count_r <= wrap_count_r + 16'd1;
                            end
                            if (irq_cnt_r + 32'd1 == IRQ_LIM) begin
                                irq_cnt_r <= 32'd0;
                                trigger_r <= 1'b1;
                            end else begin
                                irq_cnt_r <= irq_cnt_r + 32'd1;
                            end
                            state_r <= enable ? WAIT_DATA : IDLE;
                        end
`ifdef DMA_WRITE_BURST_SCHEDULER_TIMEOUT_EN
                    end else if (wd_cnt_r == WD_LAST) begin
                        busy_r  <= 1'b0;
                        error_r <= 1'b1;
                        state_r <= ERROR;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + 16'd1;
`endif
                    end
                end
                ERROR: begin
                    state_r <= ERROR;
                end
                default: begin
                    // An illegal encoding is treated like a fault: park and flag it.
                    state_r <= ERROR;
                    busy_r  <= 1'b0;
                    error_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.burst_start   = burst_start_r;
    assign bus.burst_addr    = burst_addr_r;
    assign trigger_interrupt = trigger_r;
    assign busy              = busy_r;
    assign error             = error_r;
    assign burst_count       = burst_count_r;
    assign wrap_count        = wrap_count_r;

endmodule
